// File: rtl/delay_sum_array_pkg.sv
// Shared helpers for the delay-and-sum array: width math and flattened-bus slicing.
`define DS_SLICE(bus, i, w) bus[(i)*(w) +: (w)]

package delay_sum_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    function automatic int sum_width(input int w, input int nch);
        return w + clog2(nch);
    endfunction

endpackage

// File: rtl/delay_sum_array_if.sv
// Sample/config/result bundle between the beamformer front end and the delay-sum stage.
interface delay_sum_array_if #(
    parameter int NCH   = 4,
    parameter int W     = 32,
    parameter int DEPTH = 16
);
    localparam int DW = delay_sum_pkg::clog2(DEPTH);
    localparam int SW = delay_sum_pkg::sum_width(W, NCH);

    logic              sum_en;
    logic              sum_rst;
    logic              srdyi_i;
    logic [NCH*W-1:0]  x_i;
    logic              cfg_we;
    logic [NCH*DW-1:0] delay_cfg;
    logic [SW-1:0]     z_o;
    logic              delay_o;

    modport master (
        output sum_en, sum_rst, srdyi_i, x_i, cfg_we, delay_cfg,
        input  z_o, delay_o
    );

    modport slave (
        input  sum_en, sum_rst, srdyi_i, x_i, cfg_we, delay_cfg,
        output z_o, delay_o
    );
endinterface

// File: rtl/delay_line_ch.sv
// One channel's circular delay buffer with zero-delay bypass and fill gating.
module delay_line_ch #(
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int DW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [DW-1:0] wp,
    input  logic [DW-1:0] fill,
    input  logic [DW-1:0] d,
    input  logic [W-1:0]  x,
    output logic [W-1:0]  s
);
    logic [W-1:0]  mem [DEPTH];
    logic [DW-1:0] rd_addr;

    always_ff @(posedge clk)
        if (we) mem[wp] <= x;

    // DW-bit subtraction wraps naturally across the pointer rollover
    assign rd_addr = wp - d;

    // Buffer is never cleared, so entries older than the fill count are masked
    always_comb begin
        s = mem[rd_addr];
        if (fill < d)
            s = '0;
        else if (d == '0)
            s = x;
    end
endmodule

// File: rtl/delay_sum_array.sv
// Multi-channel programmable delay-and-sum: per-channel delay lines, two-stage sum pipeline.
module delay_sum_array
    import delay_sum_pkg::*;
#(
    parameter int NCH   = 4,
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input logic              clk,
    input logic              GlobalReset,
    delay_sum_array_if.slave bus
);
    localparam int DW     = clog2(DEPTH);
    localparam int SW     = sum_width(W, NCH);
    localparam int STAGES = 2;

    logic                   acc;
    logic [DW-1:0]          wp, fill;
    logic [NCH-1:0][DW-1:0] d_q;
    logic [NCH-1:0][W-1:0]  s_c, s1;
    logic [STAGES-1:0]      vld_pipe;
    logic signed [SW-1:0]   sum_c, z_q;

    assign acc = bus.srdyi_i & bus.sum_en & ~bus.sum_rst;

    for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
        delay_line_ch #(.W(W), .DEPTH(DEPTH), .DW(DW)) u_line (
            .clk  (clk),
            .we   (acc),
            .wp   (wp),
            .fill (fill),
            .d    (d_q[ch]),
            .x    (`DS_SLICE(bus.x_i, ch, W)),
            .s    (s_c[ch])
        );
    end

    always_ff @(posedge clk) begin
        if (GlobalReset || bus.sum_rst) begin
            wp   <= '0;
            fill <= '0;
        end else if (acc) begin
            wp <= wp + 1'b1;
            if (fill != DW'(DEPTH - 1)) fill <= fill + 1'b1;
        end
    end

    // Codes survive a stream restart; the sample accepted this edge already used the old ones
    always_ff @(posedge clk) begin
        if (GlobalReset)     d_q <= '0;
        else if (bus.cfg_we) d_q <= bus.delay_cfg;
    end

    always_ff @(posedge clk)
        if (acc) s1 <= s_c;

    always_ff @(posedge clk) begin
        if (GlobalReset || bus.sum_rst) vld_pipe <= '0;
        else                            vld_pipe <= {vld_pipe[STAGES-2:0], acc};
    end

    always_comb begin
        sum_c = '0;
        for (int c = 0; c < NCH; c++)
            sum_c = sum_c + SW'($signed(s1[c]));
    end

    // A restart discards the sample sitting in stage 1, so the result holds
    always_ff @(posedge clk) begin
        if (GlobalReset)                         z_q <= '0;
        else if (!bus.sum_rst && vld_pipe[0])    z_q <= sum_c;
    end

    assign bus.z_o     = z_q;
    assign bus.delay_o = vld_pipe[STAGES-1];
endmodule

// File: tb/tb_delay_sum_array.sv
// Directed + short random bench for delay_sum_array with a cycle-stamped scoreboard.
module tb_delay_sum_array;
    import delay_sum_pkg::*;

    localparam int NCH   = 4;
    localparam int W     = 32;
    localparam int DEPTH = 16;
    localparam int DW    = clog2(DEPTH);
    localparam int SW    = W + clog2(NCH);

    logic clk = 1'b0;
    logic GlobalReset;
    always #5 clk = ~clk;

    delay_sum_array_if #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) bus ();

    delay_sum_array #(.NCH(NCH), .W(W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .bus         (bus)
    );

    typedef struct {
        logic [SW-1:0] z;
        int            due;
    } exp_t;

    exp_t                   sb[$];
    logic [NCH*W-1:0]       hist[$];
    logic [NCH-1:0][DW-1:0] dq;
    int                     cnt = 0;
    int                     cyc = 0;
    int                     n_assert = 0;
    int                     n_fail = 0;
    bit                     mon_en = 0;
    logic [SW-1:0]          z_hold;
    logic signed [SW-1:0]   zmin;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [SW-1:0] obs, input logic [SW-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [NCH*W-1:0] pk(input int a, input int b, input int c, input int d);
        return {W'(d), W'(c), W'(b), W'(a)};
    endfunction

    function automatic logic [NCH*DW-1:0] cf(input int a, input int b, input int c, input int d);
        return {DW'(d), DW'(c), DW'(b), DW'(a)};
    endfunction

    // Anything due after the current cycle is still in the pipe and is lost on a reset
    task automatic flush(input int now);
        exp_t keep[$];
        foreach (sb[i]) if (sb[i].due <= now) keep.push_back(sb[i]);
        sb = keep;
    endtask

    task automatic drive(input bit gr, input bit rst, input bit en, input bit s, input bit we,
                         input logic [NCH*DW-1:0] cfg, input logic [NCH*W-1:0] x);
        longint            sum;
        logic signed [W-1:0] v;
        logic [NCH*W-1:0]  h;
        int                dc;
        GlobalReset   = gr;
        bus.sum_rst   = rst;
        bus.sum_en    = en;
        bus.srdyi_i   = s;
        bus.cfg_we    = we;
        bus.delay_cfg = cfg;
        bus.x_i       = x;
        if (gr || rst) begin
            flush(cyc);
            hist.delete();
            cnt = 0;
            if (gr) dq = '0;
        end else if (s && en) begin
            sum = 0;
            for (int c = 0; c < NCH; c++) begin
                dc = int'(dq[c]);
                if (dc == 0) begin
                    v = x[c*W +: W];
                end else if (cnt >= dc) begin
                    h = hist[cnt - dc];
                    v = h[c*W +: W];
                end else begin
                    v = '0;
                end
                sum += longint'(v);
            end
            hist.push_back(x);
            cnt++;
            sb.push_back('{SW'(sum), cyc + 2});
        end
        if (we && !gr) dq = cfg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 1, 0, 0, '0, '0);
    endtask

    task automatic strobe(input logic [NCH*W-1:0] x);
        drive(0, 0, 1, 1, 0, '0, x);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].due == cyc) begin
                check_bit("delay_o pulse", bus.delay_o, 1'b1);
                check("z_o", bus.z_o, sb[0].z);
                void'(sb.pop_front());
            end else begin
                check_bit("delay_o idle", bus.delay_o, 1'b0);
            end
        end
    end

    initial begin
        dq = '0;
        zmin = -(SW'(1) <<< (W + 1));
        repeat (3) drive(1, 0, 0, 0, 0, '0, '0);
        mon_en = 1;
        check("reset z_o", bus.z_o, '0);
        check_bit("reset delay_o", bus.delay_o, 1'b0);

        // zero delay, explicit t+2 check
        strobe(pk(1, 2, 3, -4));
        idle(1);
        check_bit("zero-delay pulse", bus.delay_o, 1'b1);
        check("zero-delay sum", bus.z_o, SW'(2));
        idle(2);

        // reset mid-stream with strobes still asserted
        strobe(pk(5, 6, 7, 8));
        strobe(pk(9, 9, 9, 9));
        repeat (3) drive(1, 0, 1, 1, 0, '0, pk(1, 1, 1, 1));
        check("mid reset z_o", bus.z_o, '0);
        check_bit("mid reset delay_o", bus.delay_o, 1'b0);
        strobe(pk(10, 20, 30, 40));
        idle(1);
        check("post-reset sum", bus.z_o, SW'(100));
        idle(2);

        // per-channel delays with fill gating: expect 0,1,3,6,10,14,18,22
        drive(0, 1, 1, 0, 1, cf(0, 1, 2, 3), '0);
        for (int n = 0; n < 8; n++) strobe(pk(n, n, n, n));
        idle(3);

        // max delay across two pointer wraps
        drive(0, 1, 1, 0, 1, cf(15, 15, 15, 15), '0);
        for (int n = 0; n < 40; n++) strobe(pk(n, n, n, n));
        idle(3);

        // code load coincident with a strobe
        drive(0, 1, 1, 0, 1, cf(1, 1, 1, 1), '0);
        for (int n = 1; n <= 3; n++) strobe(pk(n, 2 * n, 3 * n, -n));
        drive(0, 0, 1, 1, 1, cf(0, 0, 0, 0), pk(4, 8, 12, -4));
        strobe(pk(5, 10, 15, -5));
        idle(3);

        // sum_en dropped for 5 cycles right behind a strobe
        drive(0, 1, 1, 0, 1, cf(2, 1, 0, 3), '0);
        for (int n = 1; n <= 4; n++) strobe(pk(n, n + 100, n + 200, n + 300));
        repeat (5) drive(0, 0, 0, 1, 0, '0, pk(77, 77, 77, 77));
        for (int n = 5; n <= 8; n++) strobe(pk(n, n + 100, n + 200, n + 300));
        idle(3);

        // sum_rst with a coincident strobe: dropped, fill restarts, z_o holds
        z_hold = bus.z_o;
        drive(0, 1, 1, 1, 0, '0, pk(999, 999, 999, 999));
        idle(2);
        check("z_o hold on sum_rst", bus.z_o, z_hold);
        for (int n = 1; n <= 5; n++) strobe(pk(n, n, n, n));
        idle(3);

        // short random mix
        for (int i = 0; i < 30; i++)
            drive(0, ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  ($urandom_range(0, 7) == 0), cf($urandom_range(0, 15), $urandom_range(0, 15),
                  $urandom_range(0, 15), $urandom_range(0, 15)),
                  pk($urandom, $urandom, $urandom, $urandom));
        idle(3);

        // signed extremes
        drive(0, 0, 1, 0, 1, cf(0, 0, 0, 0), '0);
        strobe(pk(32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000));
        idle(1);
        check("signed min sum", bus.z_o, zmin);
        idle(3);

        check("scoreboard drained", SW'(sb.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/delay_sum_array.md
# delay_sum_array

Parametrised multi-channel delay-and-sum stage for the beamforming datapath. Each of `NCH` signed input channels passes through its own programmable sample delay (0 to `DEPTH-1` samples, circular buffer). The delayed samples are summed into one full-precision output with a one-cycle valid pulse. It replaces the single-channel, fixed one-sample delay_sum stage and adds per-channel runtime-programmable delays, channel summation and a defined fill behaviour.

## Interface
Parameters:
- `NCH`, 4: number of input channels (≥1)
- `W`, 32: sample width, signed two's complement
- `DEPTH`, 16: delay buffer entries per channel, power of two ≥2
- `DW`, clog2(`DEPTH`): delay-code width (derived, not overridden)
- `SW`, `W`+clog2(`NCH`): sum width (derived)

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `GlobalReset` in 1: synchronous, active-high reset
- `sum_en` in 1: enables sample acceptance
- `sum_rst` in 1: synchronous stream restart (pointer/fill/pipeline clear), lower priority than `GlobalReset`
- `srdyi_i` in 1: input sample strobe, all channels valid this cycle
- `x_i` in `NCH*W`: channel samples, ch0 in bits [W-1:0]
- `cfg_we` in 1: load delay codes
- `delay_cfg` in `NCH*DW`: per-channel delay in samples, ch0 in LSBs
- `z_o` out `SW`: signed sum of delayed samples
- `delay_o` out 1: one-cycle pulse, `z_o` new this cycle

## Operation
- Accept condition: `acc = srdyi_i & sum_en & ~sum_rst`.
- On `acc`:
  - Each channel writes `x_i[ch]` to `mem[ch][wp]`.
  - Each channel reads its delayed sample `s_ch`:
    - `d_ch == 0`: `s_ch` = live `x_i[ch]` (bypass, no buffer read).
    - else: `s_ch = mem[ch][(wp - d_ch) mod DEPTH]`.
  - `wp` increments and wraps `DEPTH-1 → 0`.
  - `fill` increments and saturates at `DEPTH-1`.
- Fill rule: when `fill < d_ch`, `s_ch` is forced to 0. The memory is never cleared, so stale contents must never reach the sum.
- Stage 1: register all `s_ch` plus valid bit `v1 = acc`.
- Stage 2: `z_o <= Σ sext(s_ch)` to `SW` bits, exact, no overflow possible. `delay_o <= v1`.
- Delay codes:
  - `cfg_we` loads `delay_cfg` into internal `d_ch` registers at the clock edge.
  - A sample accepted in the same cycle uses the old codes; new codes apply from the next accepted sample.
  - Codes are not cleared by `sum_rst`.
- `sum_en` low: no writes, `wp`/`fill` hold. Stage 1 and stage 2 still drain, so a sample in flight still produces its `delay_o` pulse.
- `sum_rst` high:
  - Clears `wp`, `fill`, `v1` and `delay_o`.
  - `z_o` holds its last value.
  - An in-flight sample is discarded.
- `GlobalReset` high:
  - Clears `wp`, `fill`, `v1`, all `d_ch`, `z_o` and `delay_o`.
  - Memory is unaffected.
- Reset values: `z_o = 0`, `delay_o = 0`.

## Timing
- Latency: `acc` in cycle t → `delay_o = 1` and valid `z_o` in cycle t+2.
- Throughput: one sample per cycle. Back-to-back strobes give back-to-back pulses.
- `delay_o` is high for exactly one cycle per accepted sample. `z_o` is stable between pulses.
- Simultaneous `GlobalReset` and anything else: reset wins.
- Simultaneous `sum_rst` and `srdyi_i`: the sample is dropped.
- Delay of `d` samples means output sample n uses input sample n−d of that channel.
- Wrap-around: `(wp - d)` uses unsigned `DW`-bit modulo arithmetic and is correct across the `wp` wrap.
- Memory read is combinational/async or registered at designer's choice. The t+2 latency is fixed either way.

## Structure
- Package `delay_sum_pkg`:
  - `clog2` function
  - sample/sum width helpers
  - flattened-bus slice macros/functions used by this block and bench
- Sub-module `delay_line_ch` (one instance per channel via generate):
  - Contents: `DEPTH×W` buffer, read-address subtract, bypass mux, fill gating.
  - Inputs: `wp`, `fill`, `d`, `we`, `x`.
  - Output: `s`.
- Top level holds: shared `wp`/`fill` counters, delay-code registers, stage-1 registers, adder and output registers.

## Test plan
- **Reset:** `GlobalReset` 3 cycles mid-stream → `z_o = 0`, `delay_o = 0`, first post-reset sample with zero codes gives the sum of live inputs at t+2.
- **Zero delay:** NCH=4, codes 0, inputs {1, 2, 3, −4} on one strobe → `z_o = 2`, `delay_o` pulse exactly at t+2.
- **Per-channel delay with fill gating:** codes {0, 1, 2, 3}, ramp `x[ch] = n` for samples n = 0..7 → outputs:
  - n=0: 0
  - n=1: 1
  - n=2: 3
  - n=3: 6
  - n ≥ 3 in general: 4n−6
- **Wrap and max delay:** DEPTH=16, all codes 15, 40 continuous strobes with `x = n` → first 15 outputs 0, then `4·(n−15)`, correct across two `wp` wraps.
- **Control corners:**
  - `cfg_we` coincident with a strobe → that sample uses old codes, the next uses new ones.
  - `sum_en` dropped for 5 cycles → `wp` holds, the in-flight pulse still emitted.
  - `sum_rst` with a coincident strobe → sample dropped, `fill` restarts (outputs zero-gated again).
- **Signed extremes:** all channels `−2^(W−1)`, NCH=4, codes 0 → `z_o = −2^(W+1)` exactly in `SW = W+2` bits.
